jtoutrun_roadpxl: RTL



---
 rtl/jtoutrun_road_pkg.sv | 25 ++
 rtl/jtoutrun_road_lbuf.sv | 23 ++
 rtl/jtoutrun_roadpxl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/jtoutrun_road_pkg.sv
// Shared types and control-word field positions for the Out Run road pixel generator.
package jtoutrun_road_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_FETCH,
        ST_DONE
    } road_st_t;

    localparam int EN_BIT         = 15;
    localparam int ROW_MSB        = 8;
    localparam int COL_LSB        = 9;
    localparam int COL_MSB        = 13;
    localparam int HPOS_MSB       = 8;
    localparam int WORDS_PER_LINE = 64;
    localparam int WORD_AW        = $clog2(WORDS_PER_LINE);

    // Pixel n of a ROM word sits in bits [15-2n -: 2]; 15-2n == {~n, 1}.
    function automatic logic [1:0] pick_pix(input logic [15:0] w, input logic [2:0] sel);
        return w[{~sel, 1'b1} -: 2];
    endfunction

endpackage

// File: rtl/jtoutrun_road_lbuf.sv
// Double-banked road line buffer: FSM writes the back bank, scan-out reads the front bank.
module jtoutrun_road_lbuf
    import jtoutrun_road_pkg::*;
(
    input  logic               clk,
    input  logic               bank,
    input  logic               we,
    input  logic [WORD_AW-1:0] wr_addr,
    input  logic [15:0]        wr_data,
    input  logic               rd_en,
    input  logic [WORD_AW-1:0] rd_addr,
    output logic [15:0]        rd_data
);

    logic [15:0] mem [0:2*WORDS_PER_LINE-1];

    // Contents are deliberately not reset; the front enable hides them until a line is fetched.
    always_ff @(posedge clk) begin
        if (we) mem[{bank, wr_addr}] <= wr_data;
        if (rd_en) rd_data <= mem[{~bank, rd_addr}];
    end

endmodule

// File: rtl/jtoutrun_roadpxl.sv
// Out Run road layer: per-line control fetch, ROM row fetch into a back buffer, offset scan-out.
// Optional JTOUTRUN_ROADPXL_LATECNT_EN adds st_late, a saturating count of late fetches.
//
//   state    | meaning
//   ST_IDLE  | after reset, waiting for the first hstart
//   ST_RD0   | road RAM address {vrender,0} presented
//   ST_RD1   | word 0 on ram_dout, address {vrender,1} presented
//   ST_FETCH | requesting ROM words 0..63 into the back bank
//   ST_DONE  | line prepared (or disabled), waiting for hstart
module jtoutrun_roadpxl
    import jtoutrun_road_pkg::*;
#(
    parameter int ROMW = 16
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            pxl_cen,
    input  logic            hstart,
    input  logic            LHBL,
    input  logic [8:0]      vrender,
    input  logic [8:0]      hdump,
    output logic [9:0]      ram_addr,
    input  logic [15:0]     ram_dout,
    output logic            rom_cs,
    output logic [ROMW-1:0] rom_addr,
    input  logic            rom_ok,
    input  logic [15:0]     rom_data,
    output logic [7:0]      pxl,
    output logic            pxl_en,
    output logic            late
`ifdef JTOUTRUN_ROADPXL_LATECNT_EN
    ,
    output logic [7:0]      st_late
`endif
);

    road_st_t st_q, st_d;

    logic [8:0]         row_q;
    logic [WORD_AW-1:0] word_q;
    logic               addr_new_q;
    logic               rd1_q;
    logic               bank_q;
    logic               bk_en_q, fr_en_q;
    logic [4:0]         bk_col_q, fr_col_q;
    logic [8:0]         bk_hpos_q, fr_hpos_q;

    logic accept, last_word, in_flight;
    logic unused_bits;

    assign unused_bits = ram_dout[14];

    assign in_flight = (st_q == ST_RD0) || (st_q == ST_RD1) || (st_q == ST_FETCH);
    // Request drops combinationally so hstart or reset withdraws it in the same cycle.
    assign rom_cs    = (st_q == ST_FETCH) & ~hstart & ~rst;
    assign accept    = rom_cs & rom_ok & ~addr_new_q;
    assign last_word = (word_q == WORD_AW'(WORDS_PER_LINE - 1));
    assign rom_addr  = ROMW'({row_q, word_q});

    always_comb begin
        st_d = st_q;
        if (hstart) begin
            st_d = ST_RD0;
        end else begin
            case (st_q)
                ST_IDLE:  st_d = ST_IDLE;
                ST_RD0:   st_d = ST_RD1;
                ST_RD1:   st_d = ram_dout[EN_BIT] ? ST_FETCH : ST_DONE;
                ST_FETCH: if (accept && last_word) st_d = ST_DONE;
                default:  st_d = st_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) st_q <= ST_IDLE;
        else     st_q <= st_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr   <= '0;
            row_q      <= '0;
            word_q     <= '0;
            addr_new_q <= 1'b0;
            rd1_q      <= 1'b0;
            bank_q     <= 1'b0;
            bk_en_q    <= 1'b0;
            bk_col_q   <= '0;
            bk_hpos_q  <= '0;
            fr_en_q    <= 1'b0;
            fr_col_q   <= '0;
            fr_hpos_q  <= '0;
            late       <= 1'b0;
        end else begin
            late       <= hstart & in_flight;
            rd1_q      <= (st_q == ST_RD1) & ~hstart;
            // rom_ok is not trusted in the first cycle after the address moves.
            addr_new_q <= ~hstart & ((st_q == ST_RD1) | accept);
            if (hstart) begin
                bank_q    <= ~bank_q;
                fr_en_q   <= bk_en_q;
                fr_col_q  <= bk_col_q;
                fr_hpos_q <= bk_hpos_q;
                bk_en_q   <= 1'b0;
                ram_addr  <= {vrender, 1'b0};
            end else begin
                if (st_q == ST_RD0) ram_addr <= {vrender, 1'b1};
                if (st_q == ST_RD1) begin
                    bk_en_q <= ram_dout[EN_BIT];
                    row_q   <= ram_dout[ROW_MSB:0];
                    word_q  <= '0;
                end
                if (rd1_q) begin
                    bk_col_q  <= ram_dout[COL_MSB:COL_LSB];
                    bk_hpos_q <= ram_dout[HPOS_MSB:0];
                end
                if (accept) word_q <= word_q + 1'b1;
            end
        end
    end

    logic [8:0]  scan_x;
    logic [15:0] rd_data;
    logic [2:0]  psel_q;
    logic        lhbl_q;
    logic [1:0]  pix;
    logic        pix_on;

    assign scan_x = hdump + fr_hpos_q;

    jtoutrun_road_lbuf u_lbuf (
        .clk     (clk),
        .bank    (bank_q),
        .we      (accept),
        .wr_addr (word_q),
        .wr_data (rom_data),
        .rd_en   (pxl_cen),
        .rd_addr (scan_x[8:3]),
        .rd_data (rd_data)
    );

    assign pix    = pick_pix(rd_data, psel_q);
    assign pix_on = lhbl_q & fr_en_q & (pix != 2'd0);

    // Pixel select and blanking travel alongside the buffer read so all three line up.
    always_ff @(posedge clk) begin
        if (rst) begin
            psel_q <= '0;
            lhbl_q <= 1'b0;
            pxl    <= '0;
            pxl_en <= 1'b0;
        end else if (pxl_cen) begin
            psel_q <= scan_x[2:0];
            lhbl_q <= LHBL;
            pxl_en <= pix_on;
            pxl    <= pix_on ? {1'b0, fr_col_q, pix} : 8'd0;
        end
    end

`ifdef JTOUTRUN_ROADPXL_LATECNT_EN
    always_ff @(posedge clk) begin
        if (rst)                         st_late <= '0;
        else if (late && st_late != 8'hFF) st_late <= st_late + 8'd1;
    end
`endif

endmodule
